// File: rtl/axil_master_arbiter.sv
// Two-requester round-robin front end for a single AXI4-Lite slave.
// One transaction in flight at a time; every handshake wait is bounded by TIMEOUT cycles.
module axil_master_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 32
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    input  logic [1:0]            m_axi_bresp,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                arvalid_q, arvalid_d, rready_q, rready_d;
    logic [1:0]          req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;

    logic                gnt_sel, expired, aw_ok, w_ok;
    logic                fin;
    logic [1:0]          fin_resp;
    logic [DATA_W-1:0]   fin_data;

    assign expired = (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        req_ready_d  = '0;
        rsp_valid_d  = '0;
        rsp_rdata_d  = '0;
        rsp_resp_d   = '0;
        timer_d      = timer_q + TW'(1);
        gnt_sel      = 1'b0;
        aw_ok        = 1'b0;
        w_ok         = 1'b0;
        fin          = 1'b0;
        fin_resp     = RESP_OKAY;
        fin_data     = '0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (req_valid != 2'b00) begin
                    gnt_sel = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
                    gnt_d   = gnt_sel;
                    addr_d  = gnt_sel ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
                    wdata_d = gnt_sel ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
                    req_ready_d[gnt_sel] = 1'b1;
                    if (req_we[gnt_sel]) begin
                        state_d   = WR_ADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_ADDR: begin
                // AW and W complete independently; a channel already done counts as ok
                aw_ok = !awvalid_q || m_axi_awready;
                w_ok  = !wvalid_q  || m_axi_wready;
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if (aw_ok && w_ok) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end else if (expired) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    fin       = 1'b1;
                    fin_resp  = RESP_SLVERR;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    bready_d = 1'b0;
                    fin      = 1'b1;
                    fin_resp = m_axi_bresp;
                end else if (expired) begin
                    bready_d = 1'b0;
                    fin      = 1'b1;
                    fin_resp = RESP_SLVERR;
                end
            end
            RD_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end else if (expired) begin
                    arvalid_d = 1'b0;
                    fin       = 1'b1;
                    fin_resp  = RESP_SLVERR;
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    rready_d = 1'b0;
                    fin      = 1'b1;
                    fin_resp = m_axi_rresp;
                    fin_data = m_axi_rdata;
                end else if (expired) begin
                    rready_d = 1'b0;
                    fin      = 1'b1;
                    fin_resp = RESP_SLVERR;
                end
            end
            DONE: begin
                timer_d      = '0;
                last_grant_d = gnt_q;
                state_d      = IDLE;
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase

        // Response outputs are loaded on the edge into DONE so the pulse lines up with that state
        if (fin) begin
            state_d              = DONE;
            rsp_valid_d[gnt_q]   = 1'b1;
            rsp_resp_d           = fin_resp;
            rsp_rdata_d          = fin_data;
        end
        if (state_d != state_q) timer_d = '0;
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            timer_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_resp_q   <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            timer_q      <= timer_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_resp_q   <= rsp_resp_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Bench for axil_master_arbiter: small AXI4-Lite slave model plus a response scoreboard.
module tb_axil_master_arbiter;

    localparam int AW = 24;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req_valid = '0, req_we = '0;
    logic [2*AW-1:0]   req_addr = '0;
    logic [2*DW-1:0]   req_wdata = '0;
    logic [1:0]        req_ready, rsp_valid, rsp_resp;
    logic [DW-1:0]     rsp_rdata;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [AW-1:0]     awaddr, araddr;
    logic [DW-1:0]     wdata, rdata;
    logic [3:0]        wstrb;
    logic [1:0]        bresp, rresp;

    always #5 clk = ~clk;

    axil_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(32)) dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
    );

    // ---------------- slave model ----------------
    logic [DW-1:0] smem [0:63];
    int            aw_delay = 0;
    bit            no_b = 0, no_r = 0;
    int            aw_cnt = 0, b_hs = 0;
    bit            got_aw = 0, got_w = 0;
    logic [5:0]    s_waddr = '0;
    logic [DW-1:0] s_wdata = '0;

    assign awready = (aw_cnt >= aw_delay);
    assign wready  = 1'b1;
    assign arready = 1'b1;
    assign bresp   = 2'b00;
    assign rresp   = 2'b00;

    initial begin
        for (int i = 0; i < 64; i++) smem[i] = '0;
        bvalid = 1'b0;
        rvalid = 1'b0;
        rdata  = '0;
    end

    always @(posedge clk) begin : slave
        bit            aw_now, w_now;
        logic [5:0]    wa;
        logic [DW-1:0] wd;
        if (rst) begin
            aw_cnt <= 0; got_aw <= 0; got_w <= 0; bvalid <= 1'b0; rvalid <= 1'b0;
        end else begin
            if (awvalid && awready) aw_cnt <= 0;
            else if (awvalid)       aw_cnt <= aw_cnt + 1;
            aw_now = got_aw || (awvalid && awready);
            w_now  = got_w  || (wvalid && wready);
            wa = (awvalid && awready) ? awaddr[7:2] : s_waddr;
            wd = (wvalid && wready) ? wdata : s_wdata;
            if (awvalid && awready) s_waddr <= awaddr[7:2];
            if (wvalid && wready)   s_wdata <= wdata;
            if (aw_now && w_now) begin
                smem[wa] <= wd;
                got_aw <= 0; got_w <= 0;
                if (!no_b) bvalid <= 1'b1;
            end else begin
                got_aw <= aw_now; got_w <= w_now;
            end
            if (bvalid && bready) begin bvalid <= 1'b0; b_hs <= b_hs + 1; end
            if (arvalid && arready && !no_r) begin rvalid <= 1'b1; rdata <= smem[araddr[7:2]]; end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { int idx; logic [DW-1:0] rdata; logic [1:0] resp; } exp_t;
    exp_t          sb[$];
    logic [DW-1:0] ref_mem [0:63];
    int            vectors = 0, miscompares = 0;
    int            rsp_cnt [2] = '{0, 0};
    int            outstanding = 0;
    int            grant_q[$];

    always @(negedge clk) begin : monitor
        exp_t e;
        int   idx;
        if (rst) begin
            outstanding = 0;
        end else begin
            if (req_ready != 2'b00) begin
                outstanding++;
                vectors++;
                if (outstanding > 1 || $countones(req_ready) != 1) begin
                    miscompares++;
                    $display("FAIL outstanding: got %0d in flight, req_ready=%b, want 1 onehot", outstanding, req_ready);
                end
            end
            if (rsp_valid != 2'b00) begin
                outstanding--;
                idx = rsp_valid[1] ? 1 : 0;
                rsp_cnt[idx]++;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL rsp_unexpected: got rsp_valid=%b, want none", rsp_valid);
                end else begin
                    e = sb.pop_front();
                    if ($countones(rsp_valid) != 1 || idx != e.idx || rsp_rdata !== e.rdata || rsp_resp !== e.resp) begin
                        miscompares++;
                        $display("FAIL rsp: got valid=%b rdata=%h resp=%b, want idx=%0d rdata=%h resp=%b",
                                 rsp_valid, rsp_rdata, rsp_resp, e.idx, e.rdata, e.resp);
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic set_cmd(input int idx, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_we[idx] = we;
        req_addr[idx*AW +: AW] = a;
        req_wdata[idx*DW +: DW] = d;
    endtask

    // Expectation for the command currently presented by requester idx
    task automatic push_exp(input int idx, input logic [1:0] resp);
        exp_t       e;
        logic [5:0] wi;
        wi      = req_addr[idx*AW+2 +: 6];
        e.idx   = idx;
        e.resp  = resp;
        e.rdata = (req_we[idx] || resp != 2'b00) ? '0 : ref_mem[wi];
        if (req_we[idx]) ref_mem[wi] = req_wdata[idx*DW +: DW];
        sb.push_back(e);
    endtask

    // Returns on the negedge at which req_ready[idx] is seen
    task automatic drive_req(input int idx, input bit we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [1:0] resp);
        bit seen = 0;
        @(negedge clk);
        set_cmd(idx, we, a, d);
        req_valid[idx] = 1'b1;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (req_ready[idx]) begin
                seen = 1;
                push_exp(idx, resp);
                req_valid[idx] = 1'b0;
            end
        end
        if (!seen) begin
            miscompares++;
            req_valid[idx] = 1'b0;
            $display("FAIL grant_wait: got no req_ready[%0d] in 100 cycles, want a grant", idx);
        end
    endtask

    task automatic wait_idle();
        int c = 0;
        while (sb.size() != 0 && c < 300) begin @(negedge clk); c++; end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending responses after 300 cycles, want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Both requesters hold valid; requester 0 writes, requester 1 reads back the same slot
    task automatic run_pair(input int n);
        int got = 0;
        int k0 = 0, k1 = 0;
        grant_q.delete();
        @(negedge clk);
        set_cmd(0, 1'b1, AW'(32'h40), $urandom);
        set_cmd(1, 1'b0, AW'(32'h40), '0);
        req_valid = 2'b11;
        for (int c = 0; c < 400 && got < n; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i]) begin
                    grant_q.push_back(i);
                    push_exp(i, 2'b00);
                    got++;
                    if (i == 0) begin k0++; set_cmd(0, 1'b1, AW'(32'h40 + 4*k0), $urandom); end
                    else        begin k1++; set_cmd(1, 1'b0, AW'(32'h40 + 4*k1), '0); end
                end
            end
        end
        req_valid = 2'b00;
        if (got < n) begin
            miscompares++;
            $display("FAIL pair_grants: got %0d grants, want %0d", got, n);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {req_ready, rsp_valid, rsp_rdata, rsp_resp, awvalid, awaddr, wvalid, wdata,
                bready, arvalid, araddr, rready};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_outs: got %h, want 0", all_outs());
        end
        vectors++;
        if (wstrb !== 4'hF) begin
            miscompares++;
            $display("FAIL wstrb: got %h, want f", wstrb);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        drive_req(0, 1'b1, AW'(32'h4), 32'hDEADBEEF, 2'b00);
        vectors++;
        if (awaddr !== AW'(32'h4) || wdata !== 32'hDEADBEEF || awvalid !== 1'b1 || wvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_fields: got awaddr=%h wdata=%h aw=%b w=%b, want 000004 deadbeef 1 1",
                     awaddr, wdata, awvalid, wvalid);
        end
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL req_ready_pulse: got %b one cycle later, want 00", req_ready);
        end
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 2'b01) begin
            miscompares++;
            $display("FAIL wr_latency: got rsp_valid=%b two cycles after accept, want 01", rsp_valid);
        end
        wait_idle();
    endtask

    task automatic test_read_back();
        drive_req(1, 1'b0, AW'(32'h4), '0, 2'b00);
        vectors++;
        if (araddr !== AW'(32'h4) || arvalid !== 1'b1 || awvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_fields: got araddr=%h ar=%b aw=%b, want 000004 1 0", araddr, arvalid, awvalid);
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 2'b10 || rsp_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL rd_latency: got rsp_valid=%b rdata=%h, want 10 deadbeef", rsp_valid, rsp_rdata);
        end
        wait_idle();
    endtask

    task automatic test_round_robin();
        int c0 = rsp_cnt[0], c1 = rsp_cnt[1];
        run_pair(4);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= grant_q.size() || grant_q[i] != i % 2) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: got %0d, want %0d", i, (i < grant_q.size()) ? grant_q[i] : -1, i % 2);
            end
        end
        vectors++;
        if (rsp_cnt[0] - c0 != 2 || rsp_cnt[1] - c1 != 2) begin
            miscompares++;
            $display("FAIL rr_counts: got %0d/%0d responses, want 2/2", rsp_cnt[0] - c0, rsp_cnt[1] - c1);
        end
    endtask

    task automatic test_aw_delay();
        int aw_hi = 0, w_hi = 0, b0 = b_hs;
        bit done = 0;
        aw_delay = 3;
        drive_req(0, 1'b1, AW'(32'h10), 32'h12345678, 2'b00);
        for (int c = 0; c < 60 && !done; c++) begin
            if (awvalid) aw_hi++;
            if (wvalid)  w_hi++;
            if (rsp_valid[0]) done = 1; else @(negedge clk);
        end
        vectors++;
        if (aw_hi != 4 || w_hi != 1 || !done) begin
            miscompares++;
            $display("FAIL aw_delay: got aw_cycles=%0d w_cycles=%0d done=%0d, want 4 1 1", aw_hi, w_hi, done);
        end
        wait_idle();
        vectors++;
        if (b_hs - b0 != 1) begin
            miscompares++;
            $display("FAIL aw_delay_b: got %0d B handshakes, want 1", b_hs - b0);
        end
        aw_delay = 0;
    endtask

    task automatic test_timeout();
        int b_hi = 0;
        bit done = 0;
        no_b = 1;
        drive_req(1, 1'b1, AW'(32'h14), 32'hCAFE0001, 2'b10);
        for (int c = 0; c < 200 && !done; c++) begin
            if (bready) b_hi++;
            if (rsp_valid[1]) done = 1; else @(negedge clk);
        end
        vectors++;
        if (b_hi != 32 || !done || bready !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout: got bready_cycles=%0d done=%0d, want 32 1", b_hi, done);
        end
        wait_idle();
        no_b = 0;
        drive_req(0, 1'b0, AW'(32'h4), '0, 2'b00);
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int c = 0;
        no_r = 1;
        drive_req(1, 1'b0, AW'(32'h4), '0, 2'b00);
        while (!rready && c < 20) begin @(negedge clk); c++; end
        vectors++;
        if (!rready) begin
            miscompares++;
            $display("FAIL rd_data_reach: got rready=0 after 20 cycles, want 1");
        end
        @(negedge clk);
        sb.delete();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_outs: got %h, want 0", all_outs());
        end
        @(negedge clk);
        rst  = 1'b0;
        no_r = 0;
        run_pair(2);
        wait_idle();
        vectors++;
        if (grant_q.size() < 2 || grant_q[0] != 0 || grant_q[1] != 1) begin
            miscompares++;
            $display("FAIL post_reset_grant: got first=%0d, want 0 then 1", (grant_q.size() > 0) ? grant_q[0] : -1);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        test_reset();
        test_single_write();
        test_read_back();
        test_round_robin();
        test_aw_delay();
        test_timeout();
        test_reset_mid();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
